// File: rtl/led_pkg.sv
// Shared encodings for LED blocks: rate selects, controller states and the
// helper that maps a rate select onto its tick limit.
package led_pkg;

    typedef enum logic [1:0] {
        RATE_1HZ   = 2'b00,
        RATE_10HZ  = 2'b01,
        RATE_100HZ = 2'b10,
        RATE_OFF   = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        S_BLINK  = 2'b00,
        S_OFF    = 2'b01,
        S_RELOAD = 2'b10
    } state_e;

    localparam int unsigned C_CNT_W = 32;

    // RATE_OFF never counts, so it shares the 1 Hz limit as a harmless default.
    function automatic logic [C_CNT_W-1:0] rate_limit(
        input rate_e              rate,
        input logic [C_CNT_W-1:0] cnt_1hz,
        input logic [C_CNT_W-1:0] cnt_10hz,
        input logic [C_CNT_W-1:0] cnt_100hz
    );
        case (rate)
            RATE_10HZ:  return cnt_10hz;
            RATE_100HZ: return cnt_100hz;
            default:    return cnt_1hz;
        endcase
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a stability counter; the stable level only
// follows the switch after it has held a new level for C_DEBOUNCE_COUNT cycles.
module switch_debouncer
    import led_pkg::*;
#(
    parameter int unsigned C_DEBOUNCE_COUNT = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_switch,
    output logic o_stable
);

    localparam logic [C_CNT_W-1:0] L_TERM = 32'(C_DEBOUNCE_COUNT - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [C_CNT_W-1:0] r_cnt;

    // Any sample that agrees with the stable level restarts the qualification window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_switch;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_stable) begin
                if (r_cnt == L_TERM) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/led_rate_controller.sv
// Blinks an LED at a rate picked by two debounced switches; any change of the
// debounced select passes through a one-cycle reload state that restarts the period.
module led_rate_controller
    import led_pkg::*;
#(
    parameter int unsigned C_CLK_COUNT_1HZ   = 50000000,
    parameter int unsigned C_CLK_COUNT_10HZ  = 5000000,
    parameter int unsigned C_CLK_COUNT_100HZ = 500000,
    parameter int unsigned C_DEBOUNCE_COUNT  = 500000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_switch_1,
    input  logic       i_switch_2,
    output logic       o_led,
    output logic [1:0] o_rate,
    output logic       o_tick
);

    logic               w_stable_1;
    logic               w_stable_2;
    rate_e              w_sel;
    logic [C_CNT_W-1:0] w_limit;

    state_e             r_state;
    state_e             w_state_nxt;
    rate_e              r_rate;
    rate_e              w_rate_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               r_led;
    logic               w_led_nxt;
    logic               r_tick;
    logic               w_tick_nxt;

    switch_debouncer #(.C_DEBOUNCE_COUNT(C_DEBOUNCE_COUNT)) u_deb_1 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_switch (i_switch_1),
        .o_stable (w_stable_1)
    );

    switch_debouncer #(.C_DEBOUNCE_COUNT(C_DEBOUNCE_COUNT)) u_deb_2 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_switch (i_switch_2),
        .o_stable (w_stable_2)
    );

    assign w_sel   = rate_e'({w_stable_2, w_stable_1});
    assign w_limit = rate_limit(r_rate, 32'(C_CLK_COUNT_1HZ), 32'(C_CLK_COUNT_10HZ),
                                32'(C_CLK_COUNT_100HZ));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_BLINK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_sel != r_rate) begin
            w_state_nxt = S_RELOAD;
        end else begin
            case (r_state)
                S_RELOAD: w_state_nxt = (r_rate == RATE_OFF) ? S_OFF : S_BLINK;
                S_OFF:    w_state_nxt = S_OFF;
                default:  w_state_nxt = S_BLINK;
            endcase
        end
    end

    // The cycle leaving S_RELOAD already counts, so the first toggle lands limit cycles after reload.
    always_comb begin
        w_rate_nxt = r_rate;
        w_cnt_nxt  = r_cnt;
        w_led_nxt  = r_led;
        w_tick_nxt = 1'b0;
        case (w_state_nxt)
            S_RELOAD: begin
                w_rate_nxt = w_sel;
                w_cnt_nxt  = '0;
                w_led_nxt  = 1'b0;
            end
            S_OFF: begin
                w_cnt_nxt = '0;
                w_led_nxt = 1'b0;
            end
            default: begin
                if (r_cnt == w_limit - 32'd1) begin
                    w_cnt_nxt  = '0;
                    w_led_nxt  = ~r_led;
                    w_tick_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rate <= RATE_1HZ;
            r_cnt  <= '0;
            r_led  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_rate <= w_rate_nxt;
            r_cnt  <= w_cnt_nxt;
            r_led  <= w_led_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    assign o_led  = r_led;
    assign o_rate = r_rate;
    assign o_tick = r_tick;

endmodule

// File: tb/tb_led_rate_controller.sv
// Directed bench for led_rate_controller with short debounce and tick limits:
// a vector table for the long blink/select sequence, hand sequences for glitches and resets.
module tb_led_rate_controller;

    logic       clk;
    logic       rst_n;
    logic       sw1;
    logic       sw2;
    logic       led;
    logic [1:0] rate;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit       sw1;
        bit       sw2;
        int       steps;
        bit       quiet;
        bit       exp_led;
        bit [1:0] exp_rate;
        bit       exp_tick;
        string    name;
    } vec_t;

    vec_t vecs[17];

    led_rate_controller #(
        .C_CLK_COUNT_1HZ   (20),
        .C_CLK_COUNT_10HZ  (8),
        .C_CLK_COUNT_100HZ (4),
        .C_DEBOUNCE_COUNT  (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_switch_1 (sw1),
        .i_switch_2 (sw2),
        .o_led      (led),
        .o_rate     (rate),
        .o_tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit s1, input bit s2);
        sw1 = s1;
        sw2 = s2;
    endtask

    task automatic checkOutput(input string name, input bit e_led, input bit [1:0] e_rate,
                               input bit e_tick);
        check({name, ".led"},  32'(led),  32'(e_led));
        check({name, ".rate"}, 32'(rate), 32'(e_rate));
        check({name, ".tick"}, 32'(tick), 32'(e_tick));
    endtask

    initial begin
        // Edge counts in the names are edges since reset release.
        vecs[0]  = '{1'b0, 1'b0, 19,  1'b0, 1'b0, 2'b00, 1'b0, "t1_e19"};
        vecs[1]  = '{1'b0, 1'b0, 1,   1'b0, 1'b1, 2'b00, 1'b1, "t1_e20_first_toggle"};
        vecs[2]  = '{1'b0, 1'b0, 1,   1'b0, 1'b1, 2'b00, 1'b0, "t1_e21"};
        vecs[3]  = '{1'b0, 1'b0, 19,  1'b0, 1'b0, 2'b00, 1'b1, "t1_e40_second_toggle"};
        vecs[4]  = '{1'b1, 1'b0, 6,   1'b0, 1'b0, 2'b00, 1'b0, "t2_e46_before_rate"};
        vecs[5]  = '{1'b1, 1'b0, 1,   1'b0, 1'b0, 2'b01, 1'b0, "t2_e47_reload"};
        vecs[6]  = '{1'b1, 1'b0, 7,   1'b0, 1'b0, 2'b01, 1'b0, "t2_e54"};
        vecs[7]  = '{1'b1, 1'b0, 1,   1'b0, 1'b1, 2'b01, 1'b1, "t2_e55_first_toggle"};
        vecs[8]  = '{1'b1, 1'b0, 8,   1'b0, 1'b0, 2'b01, 1'b1, "t2_e63_second_toggle"};
        vecs[9]  = '{1'b1, 1'b1, 6,   1'b0, 1'b0, 2'b01, 1'b0, "t4_e69_before_off"};
        vecs[10] = '{1'b1, 1'b1, 1,   1'b0, 1'b0, 2'b11, 1'b0, "t4_e70_reload_off"};
        vecs[11] = '{1'b1, 1'b1, 100, 1'b1, 1'b0, 2'b11, 1'b0, "t4_e170_off_quiet"};
        vecs[12] = '{1'b0, 1'b0, 6,   1'b0, 1'b0, 2'b11, 1'b0, "t4_e176_still_off"};
        vecs[13] = '{1'b0, 1'b0, 1,   1'b0, 1'b0, 2'b00, 1'b0, "t4_e177_reload_1hz"};
        vecs[14] = '{1'b0, 1'b0, 19,  1'b0, 1'b0, 2'b00, 1'b0, "t4_e196"};
        vecs[15] = '{1'b0, 1'b0, 1,   1'b0, 1'b1, 2'b00, 1'b1, "t4_e197_toggle"};
        vecs[16] = '{1'b0, 1'b0, 20,  1'b0, 1'b0, 2'b00, 1'b1, "t4_e217_toggle"};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        step(3);
        checkOutput("reset_state", 1'b0, 2'b00, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sw1, vecs[i].sw2);
            for (int s = 0; s < vecs[i].steps; s++) begin
                step(1);
                if (vecs[i].quiet) begin
                    check({vecs[i].name, ".quiet_tick"}, 32'(tick), 32'd0);
                    check({vecs[i].name, ".quiet_led"},  32'(led),  32'd0);
                end
            end
            checkOutput(vecs[i].name, vecs[i].exp_led, vecs[i].exp_rate, vecs[i].exp_tick);
        end

        // Three-cycle glitches on switch 2 must never reach the debounced select.
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        for (int g = 0; g < 2; g++) begin
            applyStimulus(1'b0, 1'b1);
            for (int s = 0; s < 3; s++) begin
                step(1);
                check("t3_glitch_high_rate", 32'(rate), 32'd0);
            end
            applyStimulus(1'b0, 1'b0);
            for (int s = 0; s < 3; s++) begin
                step(1);
                check("t3_glitch_low_rate", 32'(rate), 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b1);
        for (int s = 0; s < 6; s++) begin
            step(1);
            check("t3_settle_wait_rate", 32'(rate), 32'd0);
        end
        step(1);
        checkOutput("t3_settle_plus7", 1'b0, 2'b10, 1'b0);
        step(3);
        checkOutput("t3_r3", 1'b0, 2'b10, 1'b0);
        step(1);
        checkOutput("t3_r4_toggle", 1'b1, 2'b10, 1'b1);
        step(4);
        checkOutput("t3_r8_toggle", 1'b0, 2'b10, 1'b1);
        step(5);
        checkOutput("t5_r13_led_on", 1'b1, 2'b10, 1'b0);

        // Asynchronous reset between clock edges while the LED is lit.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_reset", 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(19);
        checkOutput("t5_e19_after_release", 1'b0, 2'b00, 1'b0);
        step(1);
        checkOutput("t5_e20_first_toggle", 1'b1, 2'b00, 1'b1);

        // Select change while lit: reload darkens the LED and restarts the period.
        applyStimulus(1'b1, 1'b0);
        step(6);
        checkOutput("t6_e26_still_lit", 1'b1, 2'b00, 1'b0);
        step(1);
        checkOutput("t6_e27_reload", 1'b0, 2'b01, 1'b0);
        step(7);
        checkOutput("t6_e34", 1'b0, 2'b01, 1'b0);
        step(1);
        checkOutput("t6_e35_first_toggle", 1'b1, 2'b01, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
